// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the 5-stage RISC-V core.
//   * Captures the decoded operands, immediate, PC, register addresses and
//     control bundle from ID. The registered rs1/rs2/rd/RegWrite fields feed
//     the EX-stage forwarding logic.
//   * Detects load-use hazards against the instruction currently in EX and
//     raises load_use_stall so PC and IF/ID hold while a bubble is inserted.
//   * Turns flushes, load-use stalls and invalid ID slots into bubbles.
//     A bubble has every field zero, so it never matches in forwarding and
//     never writes a register or memory.
//   * Keeps saturating stall and flush event counters.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_id, pc_id             ID instruction valid / PC
//   rs1_id, rs2_id, rd_id       decoded register addresses
//   uses_rs1_id, uses_rs2_id    instruction really reads rs1 / rs2
//   rs1_data_id, rs2_data_id    register file read data
//   imm_id, ctrl_id             immediate, control bundle
//                               ctrl: [0] RegWrite [1] MemRead [2] MemWrite
//                                     [3] MemtoReg [4] ALUSrc  [8:5] ALUOp
//   flush                       redirect from EX, kill the ID instruction
//   ext_stall                   global freeze, hold all state
//   *_id_ex                     registered fields presented to EX
//   load_use_stall              combinational freeze request for PC/IF/ID
//   stall_cnt, flush_cnt        saturating event counters
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [REG_W-1:0]  rs1_id,
    input  logic [REG_W-1:0]  rs2_id,
    input  logic [REG_W-1:0]  rd_id,
    input  logic              uses_rs1_id,
    input  logic              uses_rs2_id,
    input  logic [XLEN-1:0]   rs1_data_id,
    input  logic [XLEN-1:0]   rs2_data_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              valid_id_ex,
    output logic [XLEN-1:0]   pc_id_ex,
    output logic [XLEN-1:0]   rs1_data_id_ex,
    output logic [XLEN-1:0]   rs2_data_id_ex,
    output logic [XLEN-1:0]   imm_id_ex,
    output logic [REG_W-1:0]  rs1_id_ex,
    output logic [REG_W-1:0]  rs2_id_ex,
    output logic [REG_W-1:0]  rd_id_ex,
    output logic [CTRL_W-1:0] ctrl_id_ex,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic hazard;
    logic load_bubble;
    logic capture;

    // A load in EX whose destination is read by the ID instruction. Loads
    // to x0 are excluded since x0 never carries a forwarded value.
    assign hazard = valid_id_ex & ctrl_id_ex[1] & (rd_id_ex != '0) & valid_id &
                    ((uses_rs1_id & (rs1_id == rd_id_ex)) |
                     (uses_rs2_id & (rs2_id == rd_id_ex)));

    // A flush kills the dependent instruction anyway, so no stall is needed.
    assign load_use_stall = hazard & ~flush;

    // flush beats ext_stall so a wrong-path instruction is never held.
    assign load_bubble = flush | (~ext_stall & (hazard | ~valid_id));
    assign capture     = ~flush & ~ext_stall & ~hazard & valid_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_id_ex    <= 1'b0;
            pc_id_ex       <= '0;
            rs1_data_id_ex <= '0;
            rs2_data_id_ex <= '0;
            imm_id_ex      <= '0;
            rs1_id_ex      <= '0;
            rs2_id_ex      <= '0;
            rd_id_ex       <= '0;
            ctrl_id_ex     <= '0;
        end else if (load_bubble) begin
            valid_id_ex    <= 1'b0;
            pc_id_ex       <= '0;
            rs1_data_id_ex <= '0;
            rs2_data_id_ex <= '0;
            imm_id_ex      <= '0;
            rs1_id_ex      <= '0;
            rs2_id_ex      <= '0;
            rd_id_ex       <= '0;
            ctrl_id_ex     <= '0;
        end else if (capture) begin
            valid_id_ex    <= 1'b1;
            pc_id_ex       <= pc_id;
            rs1_data_id_ex <= rs1_data_id;
            rs2_data_id_ex <= rs2_data_id;
            imm_id_ex      <= imm_id;
            rs1_id_ex      <= rs1_id;
            rs2_id_ex      <= rs2_id;
            rd_id_ex       <= rd_id;
            ctrl_id_ex     <= ctrl_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end else if (!ext_stall && hazard) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection and bubble insertion. It captures decoded operands and control from ID and presents the registered rs1/rs2/rd/RegWrite fields that the EX-stage operand forwarding logic consumes. It raises a stall toward PC/IF/ID on load-use hazards, converts flushes and stalls into bubbles, and keeps saturating counters for stall and flush events.

Parameters:
XLEN, 32, data/PC width
REG_W, 5, register address width (matches `REG_W in def.h)
CTRL_W, 9, control bundle width: [0] RegWrite, [1] MemRead, [2] MemWrite, [3] MemtoReg, [4] ALUSrc, [8:5] ALUOp
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
valid_id  in  1  ID holds a real instruction
pc_id  in  XLEN  PC of the ID instruction
rs1_id, rs2_id, rd_id  in  REG_W  register addresses from decode
uses_rs1_id, uses_rs2_id  in  1  instruction actually reads rs1/rs2
rs1_data_id, rs2_data_id, imm_id  in  XLEN  register file read data and immediate
ctrl_id  in  CTRL_W  decoded control bundle
flush  in  1  branch/jump redirect from EX; kill the ID instruction
ext_stall  in  1  global freeze (memory wait); hold all state
valid_id_ex  out  1  EX holds a real instruction
pc_id_ex, rs1_data_id_ex, rs2_data_id_ex, imm_id_ex  out  XLEN  registered fields
rs1_id_ex, rs2_id_ex, rd_id_ex  out  REG_W  registered addresses (to forwarding logic)
ctrl_id_ex  out  CTRL_W  registered control
load_use_stall  out  1  combinational; freeze PC and IF/ID this cycle
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst_n=0, async): every registered output is 0, including valid_id_ex, ctrl_id_ex, and both counters. Takes effect immediately and overrides any in-flight capture. The first capture is on the first rising clk edge after rst_n deasserts.
- hazard = valid_id_ex & ctrl_id_ex[1] & (rd_id_ex!=0) & valid_id & ((uses_rs1_id & rs1_id==rd_id_ex) | (uses_rs2_id & rs2_id==rd_id_ex)).
- load_use_stall = hazard & ~flush. This signal is independent of ext_stall.
- Bubble: valid_id_ex=0, ctrl_id_ex=0, rs1_id_ex=rs2_id_ex=rd_id_ex=0, and all data fields 0. A bubble never matches in forwarding and never writes a register or memory.
- Per-edge update, in priority order:
  1. flush: load a bubble. flush_cnt+1.
  2. ext_stall: hold every register unchanged. No counter changes.
  3. hazard: load a bubble. stall_cnt+1. IF/ID holds, so the dependent instruction is re-presented on the next cycle.
  4. Otherwise: capture all ID inputs. If valid_id=0, capture as a bubble.
- Latency: 1 cycle from ID inputs to outputs. A load-use hazard costs exactly 1 bubble. On the cycle after the bubble, hazard is 0 because the load has left ID/EX.
- flush and ext_stall in the same cycle: flush wins, so the wrong-path instruction is never held.
- flush and hazard in the same cycle: bubble, load_use_stall=0, and only flush_cnt increments.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- The rd==0 check prevents false stalls on loads to x0.

Test Plan:
- Reset mid-operation: assert rst_n=0 while valid_id_ex=1 and ctrl_id_ex=0x1F -> all outputs 0 before the next clk edge; counters 0.
- Load-use hazard: lw x5 in EX (ctrl[1]=1, rd=5), ID holds add x6,x5,x7 (uses_rs1=1, rs1=5) -> load_use_stall=1 for 1 cycle; next cycle valid_id_ex=0 and ctrl_id_ex=0; the cycle after, the add is captured with rs1_id_ex=5; stall_cnt=1.
- False-hazard guards: (a) lw x0 followed by a use of x0 -> no stall; (b) lw x5 followed by an instruction with rs2=5 but uses_rs2_id=0 -> no stall; in both cases the ID instruction is captured normally.
- Flush priority: flush=1 together with hazard=1 and ext_stall=1 -> load_use_stall=0, a bubble is loaded, flush_cnt=1, stall_cnt unchanged.
- Freeze: ext_stall=1 for 3 cycles with changing ID inputs -> all outputs constant across the 3 cycles; normal capture resumes on the first edge after release.
- Saturation: CNT_W=4, drive 20 consecutive flush cycles -> flush_cnt reaches 15 and stays at 15.
